pad_link_tx: RTL

//  Serialises the local player's button states (left/right/attack) onto one GPIO wire as a framed, UART-like link.
//  A second board receives the frame and drives its Player 2 inputs from it.

---
 rtl/demoman_link_pkg.sv | 30 +++
 rtl/bit_timer.sv | 32 +++
 rtl/pad_link_tx.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/demoman_link_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | demoman_link_pkg: shared definitions for the pad link tx/rx pair.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package demoman_link_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4,
    GAP   = 3'd5
  } link_state_t;

  localparam int LINK_DATA_BITS  = 3;
  localparam int LINK_FRAME_BITS = LINK_DATA_BITS + 3;

  // Data bit positions, sent LSB first after the start bit.
  localparam int LINK_BIT_LEFT   = 0;
  localparam int LINK_BIT_RIGHT  = 1;
  localparam int LINK_BIT_ATTACK = 2;

  function automatic logic link_parity(input logic [LINK_DATA_BITS-1:0] i_data);
    return ^i_data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bit_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bit_timer: free-running bit-period divider, tick on terminal count.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bit_timer #(
  parameter int BIT_CYCLES = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam logic [15:0] c_LAST_CNT = 16'(BIT_CYCLES - 1);

  logic [15:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (!run || (r_cnt == c_LAST_CNT)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign tick = run && (r_cnt == c_LAST_CNT);

endmodule
`default_nettype wire

// File: rtl/pad_link_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pad_link_tx: serialises button state into a framed one-wire link.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pad_link_tx
  import demoman_link_pkg::*;
#(
  parameter int BIT_CYCLES     = 434,
  parameter int REFRESH_CYCLES = 500000,
  parameter int GAP_BITS       = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_attack,
  output logic       tx_line,
  output logic       busy,
  output logic       frame_sent,
  output logic [7:0] frame_count
);

  localparam logic [23:0] c_REFRESH_LAST = 24'(REFRESH_CYCLES - 1);
  localparam logic [3:0]  c_GAP_LAST     = 4'(GAP_BITS - 1);
  localparam logic [1:0]  c_DATA_LAST    = 2'(LINK_DATA_BITS - 1);

  link_state_t               r_state;
  link_state_t               w_next;
  logic [LINK_DATA_BITS-1:0] w_cur;
  logic [LINK_DATA_BITS-1:0] r_shift;
  logic [LINK_DATA_BITS-1:0] r_last;
  logic                      r_par;
  logic [1:0]                r_idx;
  logic [3:0]                r_gap;
  logic [23:0]               r_refresh;
  logic [7:0]                r_count;
  logic                      w_tick;
  logic                      w_trigger;
  logic                      w_start;
  logic                      w_run;

  always_comb begin
    w_cur                  = '0;
    w_cur[LINK_BIT_LEFT]   = btn_left;
    w_cur[LINK_BIT_RIGHT]  = btn_right;
    w_cur[LINK_BIT_ATTACK] = btn_attack;
  end

  assign w_trigger = enable && ((w_cur != r_last) || (r_refresh == c_REFRESH_LAST));
  assign w_start   = (r_state == IDLE) && w_trigger;
  assign w_run     = (r_state != IDLE);

  bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk (clk),
    .rst (rst),
    .run (w_run),
    .tick(w_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    tx_line    = 1'b1;
    frame_sent = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_trigger) w_next = START;
      end
      START: begin
        tx_line = 1'b0;
        if (w_tick) w_next = DATA;
      end
      DATA: begin
        tx_line = r_shift[0];
        if (w_tick && (r_idx == c_DATA_LAST)) w_next = PAR;
      end
      PAR: begin
        tx_line = r_par;
        if (w_tick) w_next = STOP;
      end
      STOP: begin
        frame_sent = w_tick;
        if (w_tick) w_next = GAP;
      end
      GAP: begin
        if (w_tick && (r_gap == c_GAP_LAST)) w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Frame payload and last_sent are captured together so that a change
  // arriving mid-frame is still seen as different once back in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift <= '0;
      r_par   <= 1'b0;
      r_last  <= '0;
      r_idx   <= '0;
      r_gap   <= '0;
    end else if (w_start) begin
      r_shift <= w_cur;
      r_par   <= link_parity(w_cur);
      r_last  <= w_cur;
      r_idx   <= '0;
      r_gap   <= '0;
    end else if (w_tick) begin
      if (r_state == DATA) begin
        r_shift <= {1'b0, r_shift[LINK_DATA_BITS-1:1]};
        r_idx   <= r_idx + 2'd1;
      end
      if (r_state == GAP) begin
        r_gap <= r_gap + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_refresh <= '0;
    end else if (!enable || w_start) begin
      r_refresh <= '0;
    end else if (r_state == IDLE) begin
      r_refresh <= r_refresh + 24'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (frame_sent) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign busy        = (r_state != IDLE);
  assign frame_count = r_count;

endmodule
`default_nettype wire
